add3_pipe: RTL and testbench
============================

Name: add3_pipe

Overview:
Parametrised, pipelined three-operand modular adder for the md5crypt MD5 cores. It is the drop-in successor of the single-cycle registered 3-input adder. The carry chain is split into STAGES skewed segments so that WIDTH-bit sums close timing at higher clock rates. A valid bit and a thread tag travel alongside the data, so interleaved per-thread MD5 contexts stay aligned with their results.

Parameters:
WIDTH, 32, operand/result width in bits
STAGES, 2, pipeline depth = number of carry-chain segments; legal 1..4; requires (STAGES-1)*SEG < WIDTH
IV, 0, WIDTH-bit value loaded into o on reset
TAG_W, 2, width of the pass-through thread tag; legal >= 1

Ports:
CLK  in  1  clock
rst  in  1  reset; synchronous, active-high
en  in  1  global pipeline advance; en=0 freezes every register
in_valid  in  1  a/b/c/tag_in carry a new operation this cycle
a  in  WIDTH  operand
b  in  WIDTH  operand
c  in  WIDTH  operand
tag_in  in  TAG_W  thread id of the operation
out_valid  out  1  o/tag_out carry a completed result this cycle
o  out  WIDTH  registered result, (a+b+c) mod 2^WIDTH
tag_out  out  TAG_W  tag of the result in o

Behaviour:
- Reset (rst=1 at a CLK edge): all stage valid bits <= 0, out_valid <= 0, o <= IV, tag_out <= 0, all carry/skew registers <= 0. rst wins over en.
- Reset mid-operation: in-flight operations are discarded. No out_valid occurs for them after reset.
- Segmenting: SEG = ceil(WIDTH/STAGES). Segment k covers bits [k*SEG, min((k+1)*SEG, WIDTH)-1]; the last segment may be narrower.
- Stage 1 (combinational front end): carry-save compress, s = a^b^c, y = majority(a,b,c)<<1 truncated to WIDTH. Then add segment 0 of s and y with carry-in 0. Register the segment-0 sum, its carry-out, the upper bits of s/y, the valid bit and the tag.
- Stage k (2..STAGES): add segment k-1 of the delayed s/y plus the registered carry from stage k-1. Register the new carry. Lower result bits move through skew registers.
- The final carry-out is discarded (mod 2^WIDTH).
- Latency: exactly STAGES enabled cycles from an edge sampling in_valid=1 to the edge that sets out_valid=1. Throughput: 1 operation per enabled cycle, back-to-back.
- en=0: no register changes, including o, out_valid and tag_out. The pipeline holds its contents and resumes losslessly when en returns to 1. in_valid is ignored while en=0 (the caller re-presents the operation).
- On an enabled edge, out_valid <= valid of the last stage.
  - If that valid is 1: o and tag_out load the new result.
  - If it is 0: o and tag_out hold their previous value, so o stays stable between results.
- Bubbles: in_valid=0 inserts a bubble. Operand values with in_valid=0 never reach o.
- STAGES=1 degenerates to o <= a+b+c in one cycle, plus valid/tag tracking. This matches the legacy block with out_valid added.
- Illegal parameters (STAGES outside 1..4, or (STAGES-1)*SEG >= WIDTH) are caught by an elaboration-time check that stops simulation with an error.

Decomposition:
- Shared include (md5.vh): ceil-div constant function, ADD3_MAX_STAGES=4, and the default tag width used by the md5crypt thread scheduler.
- One natural sub-module: add_seg. It is a parameter-width segment adder with registered sum and carry-out, and an en/rst port. It is instantiated STAGES times in a generate loop; skew and tag/valid shift registers stay in add3_pipe.

Test Plan:
- WIDTH=32, STAGES=2, IV=0: a=FFFFFFFF, b=00000001, c=00000000, in_valid=1 -> out_valid=1 exactly 2 cycles later, o=00000000. Exercises the carry crossing the segment boundary.
- Back-to-back stream: (1,2,3), (FFFFFFFF,FFFFFFFF,FFFFFFFF), (80000000,80000000,12345678) with tags 0,1,2 -> o = 6, FFFFFFFD, 12345678 with tags 0,1,2 on 3 consecutive cycles.
- Stall: issue a=10, b=20, c=30, then en=0 for 5 cycles after the first stage -> out_valid stays 0 and o is unchanged during the stall; o=60 appears one enabled cycle after en returns.
- Reset mid-flight: IV=67452301, issue two operations, assert rst on the next edge -> o=67452301, out_valid=0, tag_out=0, and no stale out_valid over the next 4 cycles.
- Bubbles: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1. o holds the first result during the bubble, and the bubble's operands never appear.
- Parameter sweep WIDTH in {32,29}, STAGES in {1,3,4}: 10k random triples -> o equals the reference model (a+b+c) mod 2^WIDTH at latency STAGES.

Source files
------------

// File: rtl/add3_pipe_pkg.sv
// Shared constants and helpers for the md5crypt three-operand adder pipeline.
package add3_pipe_pkg;

  localparam int unsigned ADD3_MAX_STAGES = 4;
  localparam int unsigned MD5_TAG_W       = 2;

  function automatic int unsigned ceil_div(int unsigned n, int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/add_seg.sv
// One carry-chain segment: W-bit add with carry-in, registered sum and carry-out.
module add_seg #(
  parameter int unsigned W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

  always_ff @(posedge CLK) begin
    if (rst) begin
      sum  <= RST_VAL;
      cout <= 1'b0;
    end else if (en) begin
      sum  <= total[W-1:0];
      cout <= total[W];
    end
  end

endmodule

// File: rtl/add3_pipe.sv
// Pipelined (a+b+c) mod 2^WIDTH: carry-save front end, then STAGES skewed carry segments
// with valid/tag riding alongside; o and tag_out hold between results.
module add3_pipe
  import add3_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter int unsigned      STAGES = 2,
  parameter logic [WIDTH-1:0] IV     = '0,
  parameter int unsigned      TAG_W  = MD5_TAG_W
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] o,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned SEG  = ceil_div(WIDTH, (STAGES == 0) ? 1 : STAGES);
  localparam int unsigned LAST = STAGES - 1;

  if (STAGES == 0 || STAGES > ADD3_MAX_STAGES || (STAGES - 1) * SEG >= WIDTH) begin : g_bad_params
    $error("add3_pipe: illegal STAGES=%0d for WIDTH=%0d", STAGES, WIDTH);
  end

  function automatic logic [WIDTH-1:0] low_mask(int unsigned n);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int unsigned j = 0; j < WIDTH; j++) m[j] = (j < n);
    return m;
  endfunction

  logic [WIDTH-1:0] s_in   [STAGES];
  logic [WIDTH-1:0] y_in   [STAGES];
  logic [WIDTH-1:0] s_q    [STAGES];
  logic [WIDTH-1:0] y_q    [STAGES];
  logic [WIDTH-1:0] skew_q [STAGES];
  logic [WIDTH-1:0] res    [STAGES];
  logic [TAG_W-1:0] t_in   [STAGES];
  logic [TAG_W-1:0] t_q    [STAGES];
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] v_q;
  logic [STAGES:0]   carry;
  logic [WIDTH-1:0]  sum_all;
  logic              unused_bits;

  // Stage inputs: stage 0 sees the carry-save compressed operands, later stages the delayed copies.
  always_comb begin
    s_in[0] = a ^ b ^ c;
    y_in[0] = ((a & b) | (a & c) | (b & c)) << 1;
    t_in[0] = tag_in;
    v_in[0] = in_valid;
    for (int unsigned i = 1; i < STAGES; i++) begin
      s_in[i] = s_q[i-1];
      y_in[i] = y_q[i-1];
      t_in[i] = t_q[i-1];
      v_in[i] = v_q[i-1];
    end
  end

  // Partial result after each stage: finished lower segments from skew plus this stage's segment.
  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      res[i] = (skew_q[i] & low_mask(i * SEG))
             | (sum_all & low_mask((i + 1) * SEG) & ~low_mask(i * SEG));
    end
  end

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < STAGES; i++) begin : g_seg
    localparam int unsigned LO = i * SEG;
    localparam int unsigned HI = ((i + 1) * SEG > WIDTH) ? WIDTH : (i + 1) * SEG;
    localparam int unsigned SW = HI - LO;
    localparam logic [SW-1:0] RV = (i == LAST) ? IV[LO +: SW] : '0;

    logic          seg_en;
    logic [SW-1:0] seg_sum;

    // The top segment is part of o, so it only loads when a valid result arrives.
    assign seg_en = (i == LAST) ? (en & v_in[i]) : en;

    add_seg #(.W(SW), .RST_VAL(RV)) u_seg (
      .CLK  (CLK),
      .rst  (rst),
      .en   (seg_en),
      .a    (s_in[i][LO +: SW]),
      .b    (y_in[i][LO +: SW]),
      .cin  (carry[i]),
      .sum  (seg_sum),
      .cout (carry[i+1])
    );

    assign sum_all[LO +: SW] = seg_sum;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        s_q[i]    <= '0;
        y_q[i]    <= '0;
        t_q[i]    <= '0;
        skew_q[i] <= (i == LAST) ? IV : '0;
      end
    end else if (en) begin
      v_q <= v_in;
      for (int unsigned i = 0; i < STAGES; i++) begin
        s_q[i] <= s_in[i];
        y_q[i] <= y_in[i];
        if (i != LAST || v_in[i]) t_q[i] <= t_in[i];
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (i != LAST || v_in[i]) skew_q[i] <= res[i-1];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign o         = res[LAST];
  assign tag_out   = t_q[LAST];

  // Final carry-out is dropped (mod 2^WIDTH); last operand copies have no consumer.
  assign unused_bits = ^{carry[STAGES], s_q[LAST], y_q[LAST]};

endmodule

// File: tb/tb_add3_pipe.sv
// Directed and random checks of add3_pipe across several WIDTH/STAGES/IV variants.
module tb_add3_pipe;

  localparam int NDUT = 8;
  localparam logic [31:0] IV1 = 32'h6745_2301;

  function automatic int stages_of(int g);
    case (g)
      0, 1:    return 2;
      2, 5:    return 1;
      3, 6:    return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int width_of(int g);
    return (g < 5) ? 32 : 29;
  endfunction

  function automatic logic [31:0] iv_of(int g);
    return (g == 1) ? IV1 : 32'h0;
  endfunction

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst, en, in_valid;
  logic [31:0] a, b, c;
  logic [1:0]  tag_in;

  logic [31:0] o_all  [NDUT];
  logic        ov_all [NDUT];
  logic [1:0]  tg_all [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned W = width_of(g);
    localparam int unsigned S = stages_of(g);
    localparam logic [W-1:0] IVP = W'(iv_of(g));

    logic [W-1:0] o_l;
    logic         ov_l;
    logic [1:0]   t_l;

    add3_pipe #(.WIDTH(W), .STAGES(S), .IV(IVP), .TAG_W(2)) u_dut (
      .CLK       (CLK),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid),
      .a         (a[W-1:0]),
      .b         (b[W-1:0]),
      .c         (c[W-1:0]),
      .tag_in    (tag_in),
      .out_valid (ov_l),
      .o         (o_l),
      .tag_out   (t_l)
    );

    assign o_all[g]  = 32'(o_l);
    assign ov_all[g] = ov_l;
    assign tg_all[g] = t_l;
  end

  // Reference: a delay line of accepted operations; result emerges STAGES enabled edges after it was presented.
  logic        hv [NDUT][4];
  logic [31:0] hs [NDUT][4];
  logic [1:0]  ht [NDUT][4];
  logic [31:0] m_o  [NDUT];
  logic        m_ov [NDUT];
  logic [1:0]  m_t  [NDUT];
  int          mk;
  logic [31:0] mmsk;

  always @(posedge CLK) begin
    for (int g = 0; g < NDUT; g++) begin
      if (rst) begin
        for (int j = 0; j < 4; j++) hv[g][j] = 1'b0;
        m_o[g]  = iv_of(g);
        m_ov[g] = 1'b0;
        m_t[g]  = 2'b0;
      end else if (en) begin
        mmsk = 32'hFFFF_FFFF >> (32 - width_of(g));
        for (int j = 3; j > 0; j--) begin
          hv[g][j] = hv[g][j-1];
          hs[g][j] = hs[g][j-1];
          ht[g][j] = ht[g][j-1];
        end
        hv[g][0] = in_valid;
        hs[g][0] = (a + b + c) & mmsk;
        ht[g][0] = tag_in;
        mk = stages_of(g) - 1;
        m_ov[g] = hv[g][mk];
        if (hv[g][mk]) begin
          m_o[g] = hs[g][mk];
          m_t[g] = ht[g][mk];
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, g, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      for (int g = 0; g < NDUT; g++) begin
        check("model_ov",  g, 32'(ov_all[g]), 32'(m_ov[g]));
        check("model_o",   g, o_all[g], m_o[g]);
        check("model_tag", g, 32'(tg_all[g]), 32'(m_t[g]));
      end
    end
  end

  task automatic step(input logic e, input logic v, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [31:0] ic, input logic [1:0] t);
    en = e; in_valid = v; a = ia; b = ib; c = ic; tag_in = t;
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string name, input int g, input logic ov, input logic [31:0] ex_o,
                            input logic [1:0] t);
    check({name, "_ov"},  g, 32'(ov_all[g]), 32'(ov));
    check({name, "_o"},   g, o_all[g], ex_o);
    check({name, "_tag"}, g, 32'(tg_all[g]), 32'(t));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = '0; tag_in = '0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk_on = 1'b1;
    expect_out("reset", 0, 0, 32'h0, 0);
    expect_out("reset_iv", 1, 0, IV1, 0);
    expect_out("reset_s1", 2, 0, 32'h0, 0);

    // Carry crossing the segment boundary.
    step(1, 1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
    expect_out("carry_e1", 0, 0, 32'h0, 0);
    step(1, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3);
    expect_out("carry", 0, 1, 32'h0, 1);

    // Back-to-back stream.
    step(1, 1, 32'h1, 32'h2, 32'h3, 0);
    expect_out("b2b_0", 0, 0, 32'h0, 1);
    step(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    expect_out("b2b_1", 0, 1, 32'h6, 0);
    step(1, 1, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 2);
    expect_out("b2b_2", 0, 1, 32'hFFFF_FFFD, 1);
    step(1, 0, 32'h5555_5555, 32'h0, 32'h0, 0);
    expect_out("b2b_3", 0, 1, 32'h1234_5678, 2);
    step(1, 0, 32'h5555_5555, 32'h0, 32'h0, 0);
    expect_out("b2b_4", 0, 0, 32'h1234_5678, 2);

    // Stall: five frozen cycles with junk presented, then one enabled edge.
    step(1, 1, 32'd10, 32'd20, 32'd30, 3);
    expect_out("stall_in", 0, 0, 32'h1234_5678, 2);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 0);
      expect_out("stall_hold", 0, 0, 32'h1234_5678, 2);
    end
    step(1, 0, 32'h0, 32'h0, 32'h0, 0);
    expect_out("stall_out", 0, 1, 32'd60, 3);
    step(1, 0, 32'h0, 32'h0, 32'h0, 0);
    expect_out("stall_after", 0, 0, 32'd60, 3);

    // Bubbles: 1,0,1.
    step(1, 1, 32'd5, 32'd6, 32'd7, 1);
    expect_out("bub_0", 0, 0, 32'd60, 3);
    step(1, 0, 32'h111, 32'h222, 32'h333, 2);
    expect_out("bub_1", 0, 1, 32'd18, 1);
    step(1, 1, 32'd1, 32'd1, 32'd1, 3);
    expect_out("bub_2", 0, 0, 32'd18, 1);
    step(1, 0, 32'h0, 32'h0, 32'h0, 0);
    expect_out("bub_3", 0, 1, 32'd3, 3);
    step(1, 0, 32'h0, 32'h0, 32'h0, 0);
    expect_out("bub_4", 0, 0, 32'd3, 3);

    // Reset mid-flight, asserted while en=0 so reset must still win.
    step(1, 1, 32'd1, 32'd1, 32'd1, 1);
    step(1, 1, 32'd2, 32'd2, 32'd2, 2);
    expect_out("pre_rst", 1, 1, 32'd3, 1);
    rst = 1'b1;
    step(0, 1, 32'd3, 32'd3, 32'd3, 3);
    rst = 1'b0;
    expect_out("rst_mid", 1, 0, IV1, 0);
    expect_out("rst_mid", 0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 32'h0, 32'h0, 32'h0, 0);
      expect_out("rst_nostale", 1, 0, IV1, 0);
    end

    // Random sweep across all variants, with occasional stalls and bubbles.
    for (int n = 0; n < 10000; n++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) != 0),
           (n % 7 == 0) ? 32'hFFFF_FFFF : $urandom,
           (n % 11 == 0) ? 32'hFFFF_FFFF : $urandom,
           $urandom, 2'($urandom));
    end
    for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 32'h0, 32'h0, 0);

    @(negedge CLK);
    #1;
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
